// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: per-requester byte
// streams in, per-requester ack/grant back out.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   last;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;

  modport master (output req, last, data, input ack, grant);
  modport slave  (input req, last, data, output ack, grant);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between
// NREQ byte-stream requesters, with a stall timeout on the lock.
//
// Handshake: requester i holds req[i] (with data/last stable) until it sees
// ack[i] high for one cycle; that cycle is the one in which uart_wr pulses.
module uart_tx_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 65535,
  localparam int TBITS   = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    rq,
  output logic                abort,
  output logic                busy,
  output logic [7:0]          uart_d,
  output logic                uart_wr,
  input  logic                uart_txrdy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK   = 2'd1,
    S_SEND   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     lw_q, lw_d;
  logic [TBITS-1:0]  timer_q, timer_d;
  logic [7:0]        ud_q, ud_d;
  logic              wr_q, wr_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              pkt_end_q, pkt_end_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand_idx;
  int                cand;

  // Rotating priority: first requester after the previous winner, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(lw_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!pick_found && rq.req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    lw_d      = lw_q;
    timer_d   = timer_q;
    ud_d      = ud_q;
    pkt_end_d = pkt_end_q;
    ack_d     = '0;
    wr_d      = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          state_d           = S_LOCK;
        end
      end
      S_LOCK: begin
        // Accept is checked before the timeout so a late byte still wins.
        if (rq.req[gidx_q] && uart_txrdy) begin
          ud_d      = rq.data[{gidx_q, 3'b000} +: 8];
          pkt_end_d = rq.last[gidx_q];
          timer_d   = '0;
          wr_d      = 1'b1;
          ack_d     = grant_q;
          state_d   = S_SEND;
        end else if (!rq.req[gidx_q]) begin
          if (timer_q == TBITS'(TIMEOUT - 1)) begin
            abort_d = 1'b1;
            grant_d = '0;
            lw_d    = gidx_q;
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TBITS'(1);
          end
        end
      end
      S_SEND: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // One idle cycle so the core's txrdy has dropped before LOCK samples it.
        if (pkt_end_q) begin
          grant_d = '0;
          lw_d    = gidx_q;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOCK;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      gidx_q    <= '0;
      lw_q      <= IW'(NREQ - 1);
      timer_q   <= '0;
      ud_q      <= '0;
      wr_q      <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      pkt_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      gidx_q    <= gidx_d;
      lw_q      <= lw_d;
      timer_q   <= timer_d;
      ud_q      <= ud_d;
      wr_q      <= wr_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      pkt_end_q <= pkt_end_d;
    end
  end

  assign rq.grant = grant_q;
  assign rq.ack   = ack_q;
  assign abort    = abort_q;
  assign busy     = busy_q;
  assign uart_d   = ud_q;
  assign uart_wr  = wr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a small
// UART core model with serial decode, and per-scenario checking tasks.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic       abort;
  logic       busy;
  logic [7:0] uart_d;
  logic       uart_wr;
  logic       uart_txrdy;
  logic       txd;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .rq         (bus),
    .abort      (abort),
    .busy       (busy),
    .uart_d     (uart_d),
    .uart_wr    (uart_wr),
    .uart_txrdy (uart_txrdy)
  );

  logic [8:0]      src_q [NREQ][$];
  logic [NREQ-1:0] hold;
  logic [7:0]      exp_q [$];
  logic [7:0]      got_q [$];
  logic [7:0]      rx_q  [$];
  int              gnt_q [$];
  int              ack_cnt [NREQ];
  int              wr_cnt, wr_bad, ack_bad, abort_cnt;
  int              divider;
  bit              rx_en, rx_busy, m_busy;
  logic            rdy_at_edge;
  int              n_checks, n_pass;

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester driver: present queue head until acked
  initial begin : req_drv
    logic [8:0] head;
    bus.req  = '0;
    bus.last = '0;
    bus.data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !hold[i]) begin
          head               = src_q[i][0];
          bus.req[i]         = 1'b1;
          bus.last[i]        = head[8];
          bus.data[8*i +: 8] = head[7:0];
        end else begin
          bus.req[i]  = 1'b0;
          bus.last[i] = 1'b0;
        end
      end
    end
  end

  // UART core model: 1 start, 8 data LSB first, 1 stop; txrdy low while shifting
  initial begin : core_model
    logic [9:0] m_sh;
    int m_bit, m_div;
    uart_txrdy = 1'b1;
    txd        = 1'b1;
    m_busy     = 1'b0;
    m_sh       = '1;
    m_bit      = 0;
    m_div      = 0;
    forever begin
      @(negedge clk);
      if (m_busy) begin
        if (m_div == divider - 1) begin
          m_div = 0;
          if (m_bit == 9) begin
            m_busy     = 1'b0;
            txd        = 1'b1;
            uart_txrdy = 1'b1;
          end else begin
            m_bit = m_bit + 1;
            txd   = m_sh[m_bit];
          end
        end else begin
          m_div = m_div + 1;
        end
      end else if (uart_wr) begin
        m_sh       = {1'b1, uart_d, 1'b0};
        m_busy     = 1'b1;
        m_bit      = 0;
        m_div      = 0;
        txd        = 1'b0;
        uart_txrdy = 1'b0;
      end
    end
  end

  // Serial decoder for divider 8: sample mid-bit
  initial begin : rx_mon
    logic [7:0] b;
    rx_busy = 1'b0;
    b       = '0;
    forever begin
      @(negedge clk);
      if (rx_en && txd === 1'b0) begin
        rx_busy = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          b[i] = txd;
        end
        repeat (8) @(negedge clk);
        rx_q.push_back(b);
        rx_busy = 1'b0;
      end
    end
  end

  initial begin : rdy_sampler
    rdy_at_edge = 1'b1;
    forever begin
      @(posedge clk);
      rdy_at_edge = uart_txrdy;
    end
  end

  // Output monitor: writes, acks, aborts, grant order, invariant violations
  initial begin : out_mon
    logic [NREQ-1:0] prev_grant;
    logic            prev_wr;
    prev_grant = '0;
    prev_wr    = 1'b0;
    wr_cnt = 0; wr_bad = 0; ack_bad = 0; abort_cnt = 0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (uart_wr === 1'b1) begin
        got_q.push_back(uart_d);
        wr_cnt = wr_cnt + 1;
        if (prev_wr || !rdy_at_edge) wr_bad = wr_bad + 1;
      end
      if ($countones(bus.ack) > 1 || (bus.ack & ~bus.grant) != '0) ack_bad = ack_bad + 1;
      for (int i = 0; i < NREQ; i++) if (bus.ack[i]) ack_cnt[i] = ack_cnt[i] + 1;
      if (abort === 1'b1) abort_cnt = abort_cnt + 1;
      if (bus.grant != '0 && bus.grant != prev_grant)
        for (int i = 0; i < NREQ; i++) if (bus.grant[i]) gnt_q.push_back(i);
      prev_grant = bus.grant;
      prev_wr    = uart_wr;
    end
  end

  task automatic wait_quiet(input int max_cycles, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) empty = 1'b0;
      if (empty && !busy && !m_busy && !rx_busy && bus.grant == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    gnt_q.delete();
    rx_q.delete();
    wr_cnt = 0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus.grant !== '0) $display("FAIL reset_grant got=%b exp=0", bus.grant); else n_pass++;
    n_checks++; if (bus.ack !== '0) $display("FAIL reset_ack got=%b exp=0", bus.ack); else n_pass++;
    n_checks++; if (abort !== 1'b0) $display("FAIL reset_abort got=%b exp=0", abort); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (uart_wr !== 1'b0) $display("FAIL reset_wr got=%b exp=0", uart_wr); else n_pass++;
    n_checks++; if (uart_d !== 8'h00) $display("FAIL reset_d got=%h exp=00", uart_d); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] e, g;
    clear_logs();
    divider = 8;
    rx_en   = 1'b1;
    src_q[0].push_back(9'h041);
    src_q[0].push_back(9'h042);
    src_q[0].push_back(9'h143);
    wait_quiet(3000, ok);
    n_checks++; if (!ok) $display("FAIL single_done got=timeout exp=idle"); else n_pass++;
    n_checks++; if (wr_cnt !== 3) $display("FAIL single_wr_cnt got=%0d exp=3", wr_cnt); else n_pass++;
    n_checks++; if (ack_cnt[0] !== 3) $display("FAIL single_ack_cnt got=%0d exp=3", ack_cnt[0]); else n_pass++;
    n_checks++; if (bus.grant !== '0) $display("FAIL single_grant_end got=%b exp=0", bus.grant); else n_pass++;
    exp_q = '{8'h41, 8'h42, 8'h43};
    n_checks++; if (rx_q.size() !== 3) $display("FAIL single_rx_cnt got=%0d exp=3", rx_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      e = exp_q[i];
      g = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL single_txd_byte%0d got=%h exp=%h", i, g, e); else n_pass++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL single_wr_byte got=%h exp=%h", g, e); else n_pass++;
    end
    rx_en = 1'b0;
  endtask

  task automatic test_contention();
    bit ok;
    logic [7:0] e, g;
    int exp_g [4];
    apply_reset();
    clear_logs();
    divider = 1;
    src_q[1].push_back(9'h111);
    src_q[3].push_back(9'h133);
    wait_quiet(500, ok);
    n_checks++; if (!ok) $display("FAIL cont_done got=timeout exp=idle"); else n_pass++;
    n_checks++; if (gnt_q.size() !== 2) $display("FAIL cont_gnt_cnt got=%0d exp=2", gnt_q.size()); else n_pass++;
    n_checks++; if (gnt_q[0] !== 1) $display("FAIL cont_first got=%0d exp=1", gnt_q[0]); else n_pass++;
    n_checks++; if (gnt_q[1] !== 3) $display("FAIL cont_second got=%0d exp=3", gnt_q[1]); else n_pass++;
    exp_q = '{8'h11, 8'h33};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL cont_byte got=%h exp=%h", g, e); else n_pass++;
    end
    clear_logs();
    for (int i = 0; i < NREQ; i++) src_q[i].push_back({1'b1, 8'hA0 + 8'(i)});
    wait_quiet(1000, ok);
    n_checks++; if (!ok) $display("FAIL cont4_done got=timeout exp=idle"); else n_pass++;
    exp_g = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (gnt_q[i] !== exp_g[i]) $display("FAIL cont4_order%0d got=%0d exp=%0d", i, gnt_q[i], exp_g[i]); else n_pass++;
    end
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL cont4_byte got=%h exp=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    logic [7:0] e, g;
    clear_logs();
    src_q[0].push_back(9'h0B0);
    src_q[0].push_back(9'h0B1);
    src_q[0].push_back(9'h0B2);
    src_q[0].push_back(9'h1B3);
    tick();
    src_q[2].push_back(9'h1C2);
    wait_quiet(1000, ok);
    n_checks++; if (!ok) $display("FAIL lock_done got=timeout exp=idle"); else n_pass++;
    n_checks++; if (gnt_q.size() !== 2 || gnt_q[0] !== 0 || gnt_q[1] !== 2)
      $display("FAIL lock_gnt_order got=%p exp=0,2", gnt_q); else n_pass++;
    n_checks++; if (ack_cnt[0] !== 4) $display("FAIL lock_ack0 got=%0d exp=4", ack_cnt[0]); else n_pass++;
    n_checks++; if (ack_cnt[2] !== 1) $display("FAIL lock_ack2 got=%0d exp=1", ack_cnt[2]); else n_pass++;
    exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC2};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL lock_byte got=%h exp=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok, seen;
    int n;
    logic [7:0] e, g;
    clear_logs();
    src_q[1].push_back(9'h05A);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (uart_wr === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) $display("FAIL to_first_wr got=none exp=pulse"); else n_pass++;
    src_q[2].push_back(9'h1C5);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n++;
      if (abort === 1'b1) break;
    end
    // SEND -> SETTLE -> LOCK is 2 cycles, then TIMEOUT cycles in LOCK
    n_checks++; if (n !== 2 + TIMEOUT) $display("FAIL to_abort_delay got=%0d exp=%0d", n, 2 + TIMEOUT); else n_pass++;
    n_checks++; if (bus.grant !== '0) $display("FAIL to_grant_at_abort got=%b exp=0", bus.grant); else n_pass++;
    tick();
    n_checks++; if (abort !== 1'b0) $display("FAIL to_abort_pulse got=%b exp=0", abort); else n_pass++;
    n_checks++; if (bus.grant !== 4'b0100) $display("FAIL to_next_grant got=%b exp=0100", bus.grant); else n_pass++;
    wait_quiet(500, ok);
    n_checks++; if (!ok) $display("FAIL to_done got=timeout exp=idle"); else n_pass++;
    exp_q = '{8'h5A, 8'hC5};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL to_byte got=%h exp=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_timeout_race();
    bit ok, seen;
    int ab0;
    logic [7:0] e, g;
    clear_logs();
    src_q[1].push_back(9'h071);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (uart_wr === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) $display("FAIL race_first_wr got=none exp=pulse"); else n_pass++;
    hold[1] = 1'b1;
    src_q[1].push_back(9'h172);
    ab0 = abort_cnt;
    // Release req so the arbiter sees it exactly when timer == TIMEOUT-1
    repeat (1 + TIMEOUT) tick();
    hold[1] = 1'b0;
    tick();
    n_checks++; if (uart_wr !== 1'b1) $display("FAIL race_wr got=%b exp=1", uart_wr); else n_pass++;
    n_checks++; if (abort !== 1'b0) $display("FAIL race_abort got=%b exp=0", abort); else n_pass++;
    wait_quiet(500, ok);
    n_checks++; if (!ok) $display("FAIL race_done got=timeout exp=idle"); else n_pass++;
    n_checks++; if (abort_cnt !== ab0) $display("FAIL race_abort_cnt got=%0d exp=%0d", abort_cnt, ab0); else n_pass++;
    exp_q = '{8'h71, 8'h72};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL race_byte got=%h exp=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nwr;
    logic [7:0] e, g;
    clear_logs();
    src_q[0].push_back(9'h0E0);
    src_q[0].push_back(9'h0E1);
    src_q[0].push_back(9'h0E2);
    src_q[0].push_back(9'h1E3);
    nwr = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (uart_wr === 1'b1) nwr++;
      if (nwr == 2) break;
    end
    n_checks++; if (nwr !== 2) $display("FAIL rmid_second_send got=%0d exp=2", nwr); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src_q[0].delete();
    n_checks++; if (bus.grant !== '0) $display("FAIL rmid_grant got=%b exp=0", bus.grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (uart_wr !== 1'b0) $display("FAIL rmid_wr got=%b exp=0", uart_wr); else n_pass++;
    src_q[3].push_back(9'h1D3);
    src_q[0].push_back(9'h1D0);
    wait_quiet(500, ok);
    n_checks++; if (!ok) $display("FAIL rmid_done got=timeout exp=idle"); else n_pass++;
    n_checks++; if (gnt_q.size() !== 3 || gnt_q[1] !== 0 || gnt_q[2] !== 3)
      $display("FAIL rmid_gnt_order got=%p exp=0,0,3", gnt_q); else n_pass++;
    exp_q = '{8'hE0, 8'hE1, 8'hD0, 8'hD3};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_checks++; if (g !== e) $display("FAIL rmid_byte got=%h exp=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_invariants();
    n_checks++; if (wr_bad !== 0) $display("FAIL inv_wr_txrdy got=%0d exp=0", wr_bad); else n_pass++;
    n_checks++; if (ack_bad !== 0) $display("FAIL inv_ack_onehot got=%0d exp=0", ack_bad); else n_pass++;
    n_checks++; if (abort_cnt !== 1) $display("FAIL inv_abort_total got=%0d exp=1", abort_cnt); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    hold     = '0;
    divider  = 8;
    rx_en    = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
